lcd_char_source_mux: RTL

//   Parametrised character fetch path between the LCD text controller and the shared

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_addr_map.sv | 33 +++
 rtl/lcd_char_source_mux.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD character fetch path.
//   BLANK_CHAR : character shown for unmapped positions/channels
//   LCD_CHARS  : default characters per screen line
//   LCD_NCH    : default number of measurement screens held in ROM
//   state_t    : fetch FSM state encoding
package lcd_pkg;

    localparam logic [7:0]  BLANK_CHAR = 8'h20;
    localparam int unsigned LCD_CHARS  = 20;
    localparam int unsigned LCD_NCH    = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lcd_addr_map.sv
// Combinational map from (channel, character position) to a ROM address.
// Ports:
//   ch          in   CW   effective channel for this fetch
//   addr        in   AW   character position within the line
//   rom_addr_c  out  RAW  ch*CHARS + addr, or 0 when the fetch is blanked
//   blank_c     out  1    position or channel outside the stored screens
module lcd_addr_map #(
    parameter int unsigned CHARS = 20,
    parameter int unsigned N_CH  = 3,
    parameter int unsigned AW    = 5,
    parameter int unsigned CW    = 2,
    parameter int unsigned RAW   = 6
) (
    input  logic [CW-1:0]  ch,
    input  logic [AW-1:0]  addr,
    output logic [RAW-1:0] rom_addr_c,
    output logic           blank_c
);

    int unsigned ch_w;
    int unsigned addr_w;
    int unsigned sum_w;

    // Work at 32 bits so the product never wraps before the final RAW-bit cast.
    always_comb begin
        ch_w       = 32'(ch);
        addr_w     = 32'(addr);
        sum_w      = ch_w * CHARS + addr_w;
        blank_c    = (addr_w >= CHARS) || (ch_w >= N_CH);
        rom_addr_c = blank_c ? '0 : RAW'(sum_w);
    end

endmodule

// File: rtl/lcd_char_source_mux.sv
// Character fetch path between the LCD text controller and the shared character ROM.
// One request at a time: accept in IDLE, wait out the ROM latency, deliver in DONE.
// The screen (channel) is latched only when position 0 is accepted, so a line never
// mixes characters from two channels.
// Ports:
//   clk        in   1    system clock
//   rst        in   1    synchronous active-high reset
//   ch_sel     in   CW   requested screen, sampled on accept of position 0
//   lcd_req    in   1    character request (level, held until lcd_valid)
//   lcd_addr   in   AW   character position within the line
//   lcd_data   out  8    character code, held between pulses
//   lcd_valid  out  1    single-cycle delivery pulse
//   busy       out  1    high from accept through the lcd_valid cycle
//   frame_ch   out  CW   channel latched for the current frame
//   rom_addr   out  RAW  registered ROM address
//   rom_data   in   8    ROM read data, valid ROM_LAT cycles after rom_addr
module lcd_char_source_mux
    import lcd_pkg::*;
#(
    parameter int unsigned CHARS   = LCD_CHARS,
    parameter int unsigned N_CH    = LCD_NCH,
    parameter int unsigned ROM_LAT = 1,
    parameter logic [7:0]  BLANK   = BLANK_CHAR,
    localparam int unsigned AW     = ($clog2(CHARS) < 1) ? 1 : $clog2(CHARS),
    localparam int unsigned CW     = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH),
    localparam int unsigned RAW    = ($clog2(CHARS * N_CH) < 1) ? 1 : $clog2(CHARS * N_CH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CW-1:0]  ch_sel,
    input  logic           lcd_req,
    input  logic [AW-1:0]  lcd_addr,
    output logic [7:0]     lcd_data,
    output logic           lcd_valid,
    output logic           busy,
    output logic [CW-1:0]  frame_ch,
    output logic [RAW-1:0] rom_addr,
    input  logic [7:0]     rom_data
);

    localparam int unsigned CNT_W = ($clog2(ROM_LAT + 1) < 1) ? 1 : $clog2(ROM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             blank_q, blank_d;
    logic [CW-1:0]    frame_ch_d;
    logic [RAW-1:0]   rom_addr_d;
    logic [7:0]       lcd_data_d;
    logic             lcd_valid_d;
    logic             busy_d;

    logic [CW-1:0]    eff_ch_c;
    logic [RAW-1:0]   map_addr_c;
    logic             map_blank_c;

    // Position 0 starts a new frame, so it uses the freshly requested channel.
    assign eff_ch_c = (lcd_addr == '0) ? ch_sel : frame_ch;

    lcd_addr_map #(
        .CHARS (CHARS),
        .N_CH  (N_CH),
        .AW    (AW),
        .CW    (CW),
        .RAW   (RAW)
    ) u_addr_map (
        .ch         (eff_ch_c),
        .addr       (lcd_addr),
        .rom_addr_c (map_addr_c),
        .blank_c    (map_blank_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        blank_d     = blank_q;
        frame_ch_d  = frame_ch;
        rom_addr_d  = rom_addr;
        lcd_data_d  = lcd_data;
        lcd_valid_d = 1'b0;
        busy_d      = busy;

        unique case (state)
            S_IDLE: begin
                // busy also covers the lcd_valid cycle, which is spent in IDLE.
                busy_d = lcd_req;
                if (lcd_req) begin
                    frame_ch_d = eff_ch_c;
                    rom_addr_d = map_addr_c;
                    blank_d    = map_blank_c;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d      = 1'b1;
                lcd_data_d  = blank_q ? BLANK : rom_data;
                lcd_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            blank_q   <= 1'b0;
            frame_ch  <= '0;
            rom_addr  <= '0;
            lcd_data  <= BLANK;
            lcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            blank_q   <= blank_d;
            frame_ch  <= frame_ch_d;
            rom_addr  <= rom_addr_d;
            lcd_data  <= lcd_data_d;
            lcd_valid <= lcd_valid_d;
            busy      <= busy_d;
        end
    end

endmodule
